// File: rtl/bus_pkg.sv
// Shared types for the register-bus initiator: FSM state encoding and bus direction codes.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts cycles spent waiting for a bus transaction to return; flags expiry on the
// cycle in which the count of waited cycles reaches TIMEOUT_CYCLES.
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int TO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_WIDTH-1:0] count_q;
    logic [TO_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds the waited cycles before the current one, so this is the last allowed cycle
    assign expired_o = enable_i && (count_q == TO_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bus_initiator.sv
// Initiator for the daisy-chained register bus: issues one host request as a single-cycle
// bus strobe, waits for it to come back from the chain tail and returns data or a timeout.
module bus_initiator
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  req_rw,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_timeout,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rw_o,
    output logic                  valid_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  rw_i,
    input  logic                  valid_i
);

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   pend_addr_q;
    logic                    pend_rw_q;
    logic                    req_ready_q;
    logic                    resp_valid_q;
    logic                    resp_timeout_q;
    logic [DATA_WIDTH-1:0]   resp_rdata_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    rw_q;
    logic                    valid_q;
    logic                    expired;
    logic                    match;

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (state_q == ISSUE),
        .enable_i (state_q == WAIT),
        .expired_o(expired)
    );

    assign match = valid_i && (addr_i == pend_addr_q) && (rw_i == pend_rw_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            pend_addr_q    <= '0;
            pend_rw_q      <= RW_READ;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_timeout_q <= 1'b0;
            resp_rdata_q   <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rw_q           <= RW_READ;
            valid_q        <= 1'b0;
        end else begin
            // Bus outputs and the response strobe are pulses; they default low every cycle
            valid_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rw_q         <= RW_READ;
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        pend_addr_q <= req_addr;
                        pend_rw_q   <= req_rw;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        rw_q        <= req_rw;
                        valid_q     <= 1'b1;
                        req_ready_q <= 1'b0;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A return seen on the expiry cycle still counts as a normal completion
                    if (match) begin
                        resp_rdata_q   <= (pend_rw_q == RW_WRITE) ? wdata_i : rdata_i;
                        resp_timeout_q <= 1'b0;
                        resp_valid_q   <= 1'b1;
                        state_q        <= RESP;
                    end else if (expired) begin
                        resp_rdata_q   <= '0;
                        resp_timeout_q <= 1'b1;
                        resp_valid_q   <= 1'b1;
                        state_q        <= RESP;
                    end
                end
                RESP: begin
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_timeout = resp_timeout_q;
    assign addr_o       = addr_q;
    assign wdata_o      = wdata_q;
    assign rdata_o      = '0;
    assign rw_o         = rw_q;
    assign valid_o      = valid_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed scoreboard bench for bus_initiator with an in-bench model of the chain tail.
module tb_bus_initiator;
    import bus_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 8;

    typedef struct packed {
        logic          timeout;
        logic [DW-1:0] rdata;
    } resp_t;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_rw;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_timeout;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] wdata_o;
    logic [DW-1:0] rdata_o;
    logic          rw_o;
    logic          valid_o;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] wdata_i;
    logic [DW-1:0] rdata_i;
    logic          rw_i;
    logic          valid_i;

    resp_t expQ[$];
    int    checks = 0;
    int    errors = 0;

    bus_initiator #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_rw      (req_rw),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_timeout(resp_timeout),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .rdata_o     (rdata_o),
        .rw_o        (rw_o),
        .valid_o     (valid_o),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_i     (rdata_i),
        .rw_i        (rw_i),
        .valid_i     (valid_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clearChain();
        valid_i = 1'b0;
        addr_i  = '0;
        wdata_i = '0;
        rdata_i = '0;
        rw_i    = 1'b0;
    endtask

    // One request through the chain; retDelay<0 means the chain never returns it
    task automatic applyStimulus(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                 input logic rw, input int retDelay, input int mismatchAt,
                                 input logic [DW-1:0] retRdata);
        resp_t e;
        int    respAt;
        int    expAt;
        logic  pulseOk;
        logic  readyOk;
        checkOutput({tag, "_readyBefore"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_wdata = wdata;
        req_rw    = rw;
        e.timeout = (retDelay < 0);
        e.rdata   = (retDelay < 0) ? '0 : ((rw == RW_WRITE) ? wdata : retRdata);
        expQ.push_back(e);
        tick();
        req_valid = 1'b0;
        checkOutput({tag, "_valid_o"}, 32'(valid_o), 32'd1);
        checkOutput({tag, "_addr_o"}, 32'(addr_o), 32'(addr));
        checkOutput({tag, "_wdata_o"}, 32'(wdata_o), 32'(wdata));
        checkOutput({tag, "_rw_o"}, 32'(rw_o), 32'(rw));
        checkOutput({tag, "_rdata_o"}, 32'(rdata_o), 32'd0);
        respAt  = -1;
        pulseOk = 1'b1;
        readyOk = (req_ready === 1'b0);
        for (int w = 0; w < 20; w++) begin
            tick();
            if (valid_o !== 1'b0) pulseOk = 1'b0;
            if (req_ready !== 1'b0) readyOk = 1'b0;
            if (resp_valid === 1'b1) begin
                respAt = w;
                break;
            end
            clearChain();
            if (w == mismatchAt) begin
                valid_i = 1'b1;
                addr_i  = addr ^ 16'h0001;
                rw_i    = rw;
                rdata_i = 16'hDEAD;
                wdata_i = 16'hBEEF;
            end
            if (w == retDelay) begin
                valid_i = 1'b1;
                addr_i  = addr;
                rw_i    = rw;
                rdata_i = retRdata;
                wdata_i = wdata;
            end
        end
        clearChain();
        expAt = (retDelay < 0) ? TO : retDelay + 1;
        checkOutput({tag, "_latency"}, 32'(respAt), 32'(expAt));
        checkOutput({tag, "_singlePulse"}, 32'(pulseOk), 32'd1);
        checkOutput({tag, "_readyLow"}, 32'(readyOk), 32'd1);
        if (respAt >= 0 && expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput({tag, "_resp_rdata"}, 32'(resp_rdata), 32'(e.rdata));
            checkOutput({tag, "_resp_timeout"}, 32'(resp_timeout), 32'(e.timeout));
        end else begin
            checkOutput({tag, "_respSeen"}, 32'(resp_valid), 32'd1);
            expQ.delete();
        end
        tick();
        checkOutput({tag, "_readyAfter"}, 32'(req_ready), 32'd1);
        checkOutput({tag, "_respDrop"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        resp_t e;
        int    accepts;
        int    issues;
        int    resps;
        int    firstResp;
        int    secondAccept;
        logic  accept;
        logic  prevV;
        logic  prevRw;
        logic  quiet;
        logic [AW-1:0] prevA;
        logic [DW-1:0] prevW;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_rw    = 1'b0;
        clearChain();
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_timeout", 32'(resp_timeout), 32'd0);
        checkOutput("rst_resp_rdata", 32'(resp_rdata), 32'd0);
        checkOutput("rst_bus", {addr_o, wdata_o}, 32'd0);
        checkOutput("rst_bus_ctl", {15'd0, rw_o, rdata_o, valid_o}, 32'd0);

        applyStimulus("rd0", 16'h0000, 16'h0000, RW_READ, 0, -1, 16'h0005);
        applyStimulus("wr1", 16'h0001, 16'hFFBB, RW_WRITE, 0, -1, 16'h0000);
        applyStimulus("tmo", 16'h0004, 16'h0000, RW_READ, -1, -1, 16'h0000);

        // A return for the timed-out request arrives while idle and must be ignored
        valid_i = 1'b1;
        addr_i  = 16'h0004;
        rw_i    = RW_READ;
        rdata_i = 16'h4444;
        tick();
        clearChain();
        checkOutput("late_respIgnored", 32'(resp_valid), 32'd0);
        tick();
        checkOutput("late_noResp", 32'(resp_valid), 32'd0);
        checkOutput("late_ready", 32'(req_ready), 32'd1);

        applyStimulus("mism", 16'h0002, 16'h0000, RW_READ, 3, 0, 16'h00A5);

        // Back-to-back: host holds req_valid; chain returns each strobe one cycle later
        accepts      = 0;
        issues       = 0;
        resps        = 0;
        firstResp    = -1;
        secondAccept = -1;
        prevV        = 1'b0;
        prevRw       = 1'b0;
        prevA        = '0;
        prevW        = '0;
        req_valid    = 1'b1;
        req_addr     = 16'h0010;
        req_wdata    = 16'h0000;
        req_rw       = RW_READ;
        for (int c = 0; c < 16; c++) begin
            if (valid_o === 1'b1) issues++;
            if (resp_valid === 1'b1) begin
                resps++;
                if (firstResp < 0) firstResp = c;
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("b2b_resp_rdata", 32'(resp_rdata), 32'(e.rdata));
                    checkOutput("b2b_resp_timeout", 32'(resp_timeout), 32'(e.timeout));
                end
            end
            valid_i = prevV;
            addr_i  = prevA;
            rw_i    = prevRw;
            wdata_i = prevW;
            rdata_i = prevA + 16'h0100;
            prevV   = valid_o;
            prevA   = addr_o;
            prevRw  = rw_o;
            prevW   = wdata_o;
            accept  = req_valid && req_ready;
            if (accept) begin
                accepts++;
                if (accepts == 2) secondAccept = c;
                e.timeout = 1'b0;
                e.rdata   = (req_rw == RW_WRITE) ? req_wdata : req_addr + 16'h0100;
                expQ.push_back(e);
            end
            tick();
            if (accept) begin
                if (accepts == 1) begin
                    req_addr  = 16'h0011;
                    req_wdata = 16'h1234;
                    req_rw    = RW_WRITE;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        clearChain();
        checkOutput("b2b_accepts", 32'(accepts), 32'd2);
        checkOutput("b2b_issues", 32'(issues), 32'd2);
        checkOutput("b2b_resps", 32'(resps), 32'd2);
        checkOutput("b2b_firstResp", 32'(firstResp), 32'd3);
        checkOutput("b2b_secondAccept", 32'(secondAccept), 32'd4);
        checkOutput("b2b_queueEmpty", 32'(expQ.size()), 32'd0);

        // Reset while waiting drops the transaction without a response
        req_valid = 1'b1;
        req_addr  = 16'h0020;
        req_wdata = 16'h0000;
        req_rw    = RW_READ;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("wrst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("wrst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("wrst_resp_timeout", 32'(resp_timeout), 32'd0);
        checkOutput("wrst_resp_rdata", 32'(resp_rdata), 32'd0);
        checkOutput("wrst_bus", {addr_o, wdata_o}, 32'd0);
        checkOutput("wrst_bus_ctl", {15'd0, rw_o, rdata_o, valid_o}, 32'd0);
        quiet = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (resp_valid !== 1'b0 || valid_o !== 1'b0) quiet = 1'b0;
        end
        checkOutput("wrst_quiet", 32'(quiet), 32'd1);

        applyStimulus("post", 16'h0030, 16'h0000, RW_READ, 2, -1, 16'h7777);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
